// File: rtl/float12_pkg.sv
// Shared float12 format constants, payload struct and accumulator FSM encoding.
package float12_pkg;

    localparam int unsigned EXP_BIAS = 15;
    localparam int unsigned EXP_MAX  = 31;

    localparam int unsigned WORD_W   = 12;
    localparam int unsigned EXP_W    = 5;
    localparam int unsigned MANT_W   = 6;
    localparam int unsigned SIG_W    = MANT_W + 1;
    localparam int unsigned GUARD_W  = 2;
    localparam int unsigned ALN_W    = SIG_W + GUARD_W;
    localparam int unsigned SUM_W    = ALN_W + 1;
    localparam int unsigned LZC_W    = 4;

    localparam int unsigned SIGN_POS = 11;
    localparam int unsigned EXP_LSB  = 6;
    localparam int unsigned MANT_LSB = 0;

    // Smaller operand contributes nothing once shifted past all guard bits.
    localparam int unsigned SHIFT_LIMIT = ALN_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float12_t;

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_ALIGN  = 2'd1,
        S_ADD    = 2'd2,
        S_NORM   = 2'd3
    } acc_state_t;

endpackage

// File: rtl/lzc_9.sv
// 9-bit leading-zero counter; an all-zero input yields 9.
module lzc_9
    import float12_pkg::*;
(
    input  logic [ALN_W-1:0] value,
    output logic [LZC_W-1:0] count
);

    // Ascending scan so the most significant set bit is the one that sticks.
    always_comb begin
        count = LZC_W'(ALN_W);
        for (int i = 0; i < int'(ALN_W); i++) begin
            if (value[i]) count = LZC_W'(int'(ALN_W) - 1 - i);
        end
    end

endmodule

// File: rtl/mult_acc_12.sv
// float12 dot-product accumulator: one term per four cycles, truncating, saturating.
module mult_acc_12
    import float12_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o
);

    acc_state_t        state_q, state_d;
    float12_t          term_q, acc_q;
    logic              last_q;
    logic [ALN_W-1:0]  big_q, small_q;
    logic [EXP_W-1:0]  exp_q;
    logic              sign_q, sub_q;
    logic [SUM_W-1:0]  sum_q;

    logic              term_zero, acc_zero, term_big;
    logic [SIG_W-1:0]  term_sig, acc_sig;
    float12_t          big_c, small_c;
    logic [SIG_W-1:0]  big_sig_c, small_sig_c;
    logic [EXP_W-1:0]  diff_c;
    logic [ALN_W-1:0]  small_aln_c;

    logic [LZC_W-1:0]  lz;
    logic              carry_c, zero_c;
    logic [EXP_W+1:0]  exp_res_c;
    logic [MANT_W-1:0] mant_c;
    float12_t          res_c;

    assign ready_o = (state_q == S_ACCEPT) && !rst_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_ACCEPT;
        else       state_q <= state_d;
    end

    // Next state: wait in ACCEPT for a handshake, then walk the pipeline once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: if (valid_i && ready_o) state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   state_d = S_ACCEPT;
            default:  state_d = S_ACCEPT;
        endcase
    end

    // Align: order by {exp, mant} with zeros forced lowest, shift the smaller.
    always_comb begin
        term_zero   = (term_q.exp == '0);
        acc_zero    = (acc_q.exp == '0);
        term_sig    = term_zero ? '0 : {1'b1, term_q.mant};
        acc_sig     = acc_zero  ? '0 : {1'b1, acc_q.mant};
        term_big    = {term_q.exp, term_sig[MANT_W-1:0]} >= {acc_q.exp, acc_sig[MANT_W-1:0]};
        big_c       = term_big ? term_q   : acc_q;
        small_c     = term_big ? acc_q    : term_q;
        big_sig_c   = term_big ? term_sig : acc_sig;
        small_sig_c = term_big ? acc_sig  : term_sig;
        diff_c      = big_c.exp - small_c.exp;
        small_aln_c = (int'(diff_c) >= int'(SHIFT_LIMIT)) ? '0
                    : ALN_W'({small_sig_c, GUARD_W'(0)} >> diff_c);
    end

    lzc_9 u_lzc (
        .value (sum_q[ALN_W-1:0]),
        .count (lz)
    );

    // Normalize and pack, flushing underflow/cancellation and saturating overflow.
    always_comb begin
        carry_c   = sum_q[SUM_W-1];
        exp_res_c = carry_c ? (7'(exp_q) + 7'd1) : (7'(exp_q) - 7'(lz));
        zero_c    = (sum_q == '0) || (exp_q == '0) || (!carry_c && (7'(lz) >= 7'(exp_q)));
        mant_c    = carry_c ? sum_q[ALN_W-1:GUARD_W+1]
                            : MANT_W'((sum_q[ALN_W-1:0] << lz) >> GUARD_W);
        res_c     = '0;
        if (zero_c) begin
            res_c = '0;
        end else if (int'(exp_res_c) >= int'(EXP_MAX)) begin
            res_c = '{sign: sign_q, exp: EXP_W'(EXP_MAX), mant: '1};
        end else begin
            res_c = '{sign: sign_q, exp: exp_res_c[EXP_W-1:0], mant: mant_c};
        end
    end

    // Datapath registers advanced by the FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            term_q  <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            big_q   <= '0;
            small_q <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                S_ACCEPT: begin
                    if (valid_i) begin
                        term_q <= float12_t'(data_i);
                        last_q <= last_i;
                    end
                end
                S_ALIGN: begin
                    big_q   <= {big_sig_c, GUARD_W'(0)};
                    small_q <= small_aln_c;
                    exp_q   <= big_c.exp;
                    sign_q  <= big_c.sign;
                    sub_q   <= term_q.sign ^ acc_q.sign;
                end
                S_ADD: begin
                    sum_q <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                   : ({1'b0, big_q} + {1'b0, small_q});
                end
                S_NORM: begin
                    if (last_q) begin
                        data_o  <= res_c;
                        valid_o <= 1'b1;
                        acc_q   <= '0;
                    end else begin
                        acc_q   <= res_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_acc_12.sv
// Scoreboard bench for mult_acc_12 with directed, hand-computed vectors.
module tb_mult_acc_12;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic [11:0] data_o;
    logic        valid_o;

    typedef struct {
        logic [11:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mult_acc_12 dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Present a term and hold it until accepted; waited = cycles ready_o was low.
    task automatic send(input logic [11:0] d, input logic last, input logic expect_out,
                        input logic [11:0] exp_val, input string name, output int waited);
        int n = 0;
        @(negedge clk_i);
        data_i  = d;
        last_i  = last;
        valid_i = 1'b1;
        #1;
        while (!ready_o && n < 20) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: ready_o never rose, got 0 expected 1", name);
        end else if (last && expect_out) begin
            sb_q.push_back('{val: exp_val, cyc: cyc + 4, name: name});
        end
        waited = n;
        @(posedge clk_i);
    endtask

    task automatic idle();
        @(negedge clk_i);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Monitor: every valid_o cycle must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_o 0x%0h at cycle %0d, expected no pulse", data_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_data"}, int'(data_o), int'(e.val));
                check({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    initial begin
        int w;
        int t;
        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", int'(ready_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_valid", int'(valid_o), 0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", int'(ready_o), 1);

        // 1.0 + 1.0 = 2.0
        send(12'h3C0, 1'b0, 1'b0, 12'h000, "two", w);
        send(12'h3C0, 1'b1, 1'b1, 12'h400, "two", w);
        idle();

        // Four 1.0 back-to-back with valid held: 4.0, ready one cycle in four.
        send(12'h3C0, 1'b0, 1'b0, 12'h000, "four", w);
        for (int i = 0; i < 3; i++) begin
            send(12'h3C0, (i == 2), 1'b1, 12'h440, "four", w);
            check("four_ready_gap", w, 3);
        end
        idle();

        // 1.5 + -1.5 cancels to +0.
        send(12'h3E0, 1'b0, 1'b0, 12'h000, "cancel", w);
        send(12'hBE0, 1'b1, 1'b1, 12'h000, "cancel", w);
        idle();

        // Exponent difference 10 contributes nothing.
        send(12'h3C0, 1'b0, 1'b0, 12'h000, "far", w);
        send(12'h140, 1'b1, 1'b1, 12'h3C0, "far", w);
        idle();

        // Overflow saturates.
        send(12'h7FF, 1'b0, 1'b0, 12'h000, "sat", w);
        send(12'h7FF, 1'b1, 1'b1, 12'h7FF, "sat", w);
        idle();

        // Single-term sequences: passthrough and exp==0 treated as zero.
        send(12'h3E0, 1'b1, 1'b1, 12'h3E0, "single", w);
        send(12'h03F, 1'b1, 1'b1, 12'h000, "single_zero", w);
        idle();

        // -1.0 + 1.5 = 0.5 (left normalize by one).
        send(12'hBC0, 1'b0, 1'b0, 12'h000, "mixed", w);
        send(12'h3E0, 1'b1, 1'b1, 12'h380, "mixed", w);
        idle();

        // Truncation: (1+1/64) + 0.5*(1+1/64) drops guard bits, no round-up.
        send(12'h3C1, 1'b0, 1'b0, 12'h000, "trunc", w);
        send(12'h381, 1'b1, 1'b1, 12'h3E1, "trunc", w);
        idle();

        // Near-cancellation underflows to +0.
        send(12'h041, 1'b0, 1'b0, 12'h000, "underflow", w);
        send(12'h840, 1'b1, 1'b1, 12'h000, "underflow", w);
        idle();

        // Reset during ADD of the second term aborts the sum.
        send(12'h3C0, 1'b0, 1'b0, 12'h000, "abort", w);
        send(12'h3C0, 1'b1, 1'b0, 12'h000, "abort", w);
        @(negedge clk_i);
        valid_i = 1'b0;
        last_i  = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_rst_ready", int'(ready_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_post_ready", int'(ready_o), 1);
        send(12'h3C0, 1'b1, 1'b1, 12'h3C0, "after_abort", w);
        idle();

        // Drain the scoreboard within a bounded window.
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        repeat (6) @(negedge clk_i);
        check("scoreboard_left", sb_q.size(), 0);
        check("hold_data_o", int'(data_o), 12'h3C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
